// File: rtl/rv32i_pkg.sv
// Shared loader types and constants for the memory preload path.
package rv32i_pkg;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_WRITE,
    LD_DONE
  } loader_state_t;

  localparam int unsigned LD_BYTE_W = 8;

  // Number of byte lanes in a word of the given width.
  function automatic int unsigned ld_lanes(input int unsigned width);
    return width / LD_BYTE_W;
  endfunction

endpackage

// File: rtl/mem_preload_loader_packer.sv
// Byte-lane packer: little-endian lane fill, lane index counter, clear-to-zero.
// Lanes not written before a clear stay zero, which gives the zero pad on a
// short final word.
module preload_byte_packer
  import rv32i_pkg::*;
#(
  parameter  int unsigned MLEN  = 32,
  localparam int unsigned BYTES = MLEN / LD_BYTE_W,
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [LD_BYTE_W-1:0] byte_data,
  output logic [MLEN-1:0]      buffer,
  output logic [IDX_W-1:0]     byte_idx,
  output logic                 word_final
);

  // Lane buffer and index: clear wins over a byte accept.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      buffer   <= '0;
      byte_idx <= '0;
    end else if (clear) begin
      buffer   <= '0;
      byte_idx <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (byte_idx == IDX_W'(i)) begin
          buffer[i*LD_BYTE_W +: LD_BYTE_W] <= byte_data;
        end
      end
      byte_idx <= byte_idx + 1'b1;
    end
  end

  // Current lane is the top lane of the word.
  always_comb begin
    word_final = (byte_idx == IDX_W'(BYTES - 1));
  end

endmodule

// File: rtl/mem_preload_loader.sv
// Memory preload initiator: packs a byte stream into MLEN-bit words, writes
// them at incrementing word addresses and holds the core in reset until the
// image is complete.
// Optional feature macro: PRELOAD_CHECKSUM_EN (adds checksum[31:0] output).
module mem_preload_loader
  import rv32i_pkg::*;
#(
  parameter int unsigned MEM_SIZE   = 4096,
  parameter int unsigned MEM_WIDTH  = $clog2(MEM_SIZE),
  parameter int unsigned MLEN       = 32,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 s_byte_valid,
  output logic                 s_byte_ready,
  input  logic [7:0]           s_byte_data,
  input  logic                 s_byte_last,
  output logic                 preload_en,
  output logic [MEM_WIDTH-1:0] preload_addr,
  output logic [MLEN-1:0]      preload_data,
  output logic                 core_hold,
  output logic                 done,
  output logic                 overflow,
  output logic                 partial,
  output logic [MEM_WIDTH:0]   word_count
`ifdef PRELOAD_CHECKSUM_EN
  ,
  output logic [31:0]          checksum
`endif
);

  localparam int unsigned BYTES = ld_lanes(MLEN);
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [MEM_WIDTH-1:0] ADDR_FIRST = MEM_WIDTH'(START_ADDR);
  localparam logic [MEM_WIDTH-1:0] ADDR_LAST  = MEM_WIDTH'(MEM_SIZE - 1);

  loader_state_t          state;
  loader_state_t          state_next;
  logic [MEM_WIDTH-1:0]   addr;
  logic                   last_seen;
  logic                   accept;
  logic                   load_start;
  logic                   pack_clear;
  logic [MLEN-1:0]        buffer;
  logic [IDX_W-1:0]       byte_idx;
  logic                   word_final;

  assign accept     = s_byte_valid && s_byte_ready;
  assign load_start = start && ((state == LD_IDLE) || (state == LD_DONE));
  assign pack_clear = load_start || (state == LD_WRITE);

  preload_byte_packer #(
    .MLEN (MLEN)
  ) u_packer (
    .clk        (clk),
    .aresetn    (aresetn),
    .clear      (pack_clear),
    .accept     (accept),
    .byte_data  (s_byte_data),
    .buffer     (buffer),
    .byte_idx   (byte_idx),
    .word_final (word_final)
  );

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= LD_IDLE;
    else          state <= state_next;
  end

  // Next-state decode; start is only honoured in IDLE and DONE.
  always_comb begin
    state_next = state;
    case (state)
      LD_IDLE:  if (start) state_next = LD_LOAD;
      LD_LOAD:  if (accept && (word_final || s_byte_last)) state_next = LD_WRITE;
      LD_WRITE: begin
        if (last_seen || (addr == ADDR_LAST)) state_next = LD_DONE;
        else                                  state_next = LD_LOAD;
      end
      LD_DONE:  if (start) state_next = LD_LOAD;
      default:  state_next = LD_IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    s_byte_ready = (state == LD_LOAD);
    preload_en   = (state == LD_WRITE);
    preload_addr = (state == LD_WRITE) ? addr   : '0;
    preload_data = (state == LD_WRITE) ? buffer : '0;
    core_hold    = (state != LD_DONE);
    done         = (state == LD_DONE);
  end

  // Address, word counter and status flags.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      addr       <= ADDR_FIRST;
      word_count <= '0;
      last_seen  <= 1'b0;
      partial    <= 1'b0;
      overflow   <= 1'b0;
    end else if (load_start) begin
      addr       <= ADDR_FIRST;
      word_count <= '0;
      last_seen  <= 1'b0;
      partial    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if ((state == LD_LOAD) && accept && s_byte_last) begin
        last_seen <= 1'b1;
        partial   <= !word_final;
      end
      if (state == LD_WRITE) begin
        word_count <= word_count + 1'b1;
        // Hold at the top address so the counter cannot wrap back to zero.
        if (addr != ADDR_LAST) addr <= addr + 1'b1;
        if (!last_seen && (addr == ADDR_LAST)) overflow <= 1'b1;
      end
    end
  end

`ifdef PRELOAD_CHECKSUM_EN
  // XOR-fold an MLEN word into 32 bits, bit i landing on bit i mod 32.
  function automatic logic [31:0] xor_fold(input logic [MLEN-1:0] d);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < MLEN; i++) begin
      r[i % 32] = r[i % 32] ^ d[i];
    end
    return r;
  endfunction

  // Running checksum over written words.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)               checksum <= '0;
    else if (load_start)        checksum <= '0;
    else if (state == LD_WRITE) checksum <= checksum + xor_fold(buffer);
  end
`endif

endmodule

// File: tb/tb_mem_preload_loader.sv
// Self-checking bench for mem_preload_loader (MEM_SIZE=4, MLEN=32).
module tb_mem_preload_loader;

  localparam int unsigned MS = 4;
  localparam int unsigned MW = 2;
  localparam int unsigned ML = 32;

  logic          clk;
  logic          aresetn;
  logic          start;
  logic          s_byte_valid;
  logic          s_byte_ready;
  logic [7:0]    s_byte_data;
  logic          s_byte_last;
  logic          preload_en;
  logic [MW-1:0] preload_addr;
  logic [ML-1:0] preload_data;
  logic          core_hold;
  logic          done;
  logic          overflow;
  logic          partial;
  logic [MW:0]   word_count;
`ifdef PRELOAD_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [MW-1:0] addr;
    logic [ML-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  mem_preload_loader #(
    .MEM_SIZE   (MS),
    .MEM_WIDTH  (MW),
    .MLEN       (ML),
    .START_ADDR (0)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .start        (start),
    .s_byte_valid (s_byte_valid),
    .s_byte_ready (s_byte_ready),
    .s_byte_data  (s_byte_data),
    .s_byte_last  (s_byte_last),
    .preload_en   (preload_en),
    .preload_addr (preload_addr),
    .preload_data (preload_data),
    .core_hold    (core_hold),
    .done         (done),
    .overflow     (overflow),
    .partial      (partial),
    .word_count   (word_count)
`ifdef PRELOAD_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every preload_en must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (preload_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", preload_addr, preload_data);
        end else begin
          e = exp_q.pop_front();
          if (preload_addr !== e.addr || preload_data !== e.data) begin
            errors++;
            $display("FAIL write_word: got addr=%0d data=%h, required addr=%0d data=%h",
                     preload_addr, preload_data, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [MW-1:0] a, input logic [ML-1:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte and hold it until accepted (bounded).
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    s_byte_valid = 1'b1;
    s_byte_data  = d;
    s_byte_last  = l;
    forever begin
      @(negedge clk);
      if (s_byte_ready === 1'b1) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: ready=%b, required 1 within 50 cycles", s_byte_ready);
        break;
      end
    end
    @(posedge clk); #1;
    s_byte_valid = 1'b0;
    s_byte_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) break;
      n++;
      if (n > 40) break;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: got done=%b, required 1", name, done);
    end
  endtask

  task automatic check_status(input string name, input logic [MW:0] wc,
                              input logic pt, input logic ov);
    @(negedge clk);
    checks++;
    if (core_hold !== 1'b0 || word_count !== wc || partial !== pt || overflow !== ov ||
        s_byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: got hold=%b wc=%0d partial=%b ovf=%b ready=%b, required hold=0 wc=%0d partial=%b ovf=%b ready=0",
               name, core_hold, word_count, partial, overflow, s_byte_ready, wc, pt, ov);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    checks++;
    if (preload_en !== 1'b0 || preload_addr !== '0 || preload_data !== '0 ||
        core_hold !== 1'b1 || done !== 1'b0 || overflow !== 1'b0 || partial !== 1'b0 ||
        word_count !== '0 || s_byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: got en=%b addr=%0d data=%h hold=%b done=%b ovf=%b partial=%b wc=%0d ready=%b, required hold=1 and all else 0",
               name, preload_en, preload_addr, preload_data, core_hold, done, overflow,
               partial, word_count, s_byte_ready);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge clk);
    check_reset_outputs("reset_state");
    #1 aresetn = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_single_word();
    pulse_start();
    push_exp(2'd0, 32'h0000_0013);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    checks++;
    if (preload_en !== 1'b1) begin
      errors++;
      $display("FAIL write_latency: got preload_en=%b one cycle after last byte, required 1", preload_en);
    end
    wait_done("single");
    check_status("single", 3'd1, 1'b0, 1'b0);
  endtask

  task automatic test_two_words();
    pulse_start();
    push_exp(2'd0, 32'h0403_0201);
    push_exp(2'd1, 32'h0807_0605);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), (i == 8));
    wait_done("two_words");
    check_status("two_words", 3'd2, 1'b0, 1'b0);
  endtask

  task automatic test_partial();
    pulse_start();
    push_exp(2'd0, 32'h0000_BBAA);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    wait_done("partial");
    check_status("partial", 3'd1, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    pulse_start();
    for (int w = 0; w < 4; w++) begin
      push_exp(MW'(w), {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)});
    end
    for (int i = 1; i <= 16; i++) send_byte(8'(i), 1'b0);
    wait_done("overflow");
    check_status("overflow", 3'd4, 1'b0, 1'b1);
    // Excess bytes are offered but must never be taken.
    s_byte_valid = 1'b1;
    s_byte_data  = 8'h55;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (s_byte_ready !== 1'b0 || preload_en !== 1'b0) begin
        errors++;
        $display("FAIL overflow_excess: got ready=%b en=%b, required 0 0", s_byte_ready, preload_en);
      end
    end
    @(posedge clk); #1;
    s_byte_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    aresetn = 1'b0;
    #2;
    checks++;
    if (core_hold !== 1'b1 || s_byte_ready !== 1'b0 || word_count !== '0) begin
      errors++;
      $display("FAIL async_abort: got hold=%b ready=%b wc=%0d, required 1 0 0", core_hold, s_byte_ready, word_count);
    end
    repeat (2) @(posedge clk);
    check_reset_outputs("reset_mid_load");
    #1 aresetn = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    push_exp(2'd0, 32'h4433_2211);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h99, 1'b1);
    push_exp(2'd1, 32'h0000_0099);
    wait_done("after_reset");
    check_status("after_reset", 3'd2, 1'b1, 1'b0);
  endtask

  task automatic test_gaps_and_start();
    logic [7:0] img [8];
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00};
    pulse_start();
    push_exp(2'd0, 32'h0000_0013);
    push_exp(2'd1, 32'h0000_0093);
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 1) == 1) pulse_start();
        else begin @(posedge clk); #1; end
      end
      send_byte(img[i], (i == 7));
    end
    wait_done("gaps");
    check_status("gaps", 3'd2, 1'b0, 1'b0);
`ifdef PRELOAD_CHECKSUM_EN
    checks++;
    if (checksum !== 32'h0000_00A6) begin
      errors++;
      $display("FAIL checksum: got %h, required 000000a6", checksum);
    end
`endif
  endtask

  initial begin
    aresetn      = 1'b0;
    start        = 1'b0;
    s_byte_valid = 1'b0;
    s_byte_data  = '0;
    s_byte_last  = 1'b0;
    #1;
    test_reset();
    test_single_word();
    test_two_words();
    test_partial();
    test_overflow();
    test_reset_mid_load();
    test_gaps_and_start();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL writes_missing: got %0d outstanding words, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
